typing_tracker: RTL and testbench

Per-player typing engine for the race game. It takes one decoded keystroke event per press, keeps the typed-character buffer and cursor, and compares the buffer against the current target word. It fetches each new word from the word-source block over a req/ack handshake and accumulates words, keystrokes, errors and elapsed time. It raises `finish` on time-limit, word-target or mixed-mode end conditions. It generalises the single-width typing counter with parametrised buffer depth, character width, tick rate and four end modes.

---
 rtl/typing_tracker.sv | 169 ++++++++++++++++
 tb/tb_typing_tracker.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typing_tracker.sv
// typing_tracker: per-player typing engine. Keeps the typed buffer and cursor,
// compares it against the fetched target word and tracks race statistics.
module typing_tracker #(
    parameter int MAX_LEN  = 25,
    parameter int CHAR_W   = 5,
    parameter int CNT_W    = 7,
    parameter int TIME_W   = 15,
    parameter int TICK_DIV = 1000000,
    parameter int TPS      = 100,
    parameter int CUR_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                state,
    input  logic [1:0]                mode,
    input  logic [CNT_W-1:0]          target,
    input  logic                      key_stb,
    input  logic [4:0]                key_code,
    input  logic [MAX_LEN*CHAR_W-1:0] word,
    input  logic [CUR_W-1:0]          word_len,
    output logic                      word_req,
    input  logic                      word_ack,
    output logic [MAX_LEN*CHAR_W-1:0] typed,
    output logic [CUR_W-1:0]          cursor,
    output logic [CUR_W-1:0]          match,
    output logic [CNT_W-1:0]          words_done,
    output logic [15:0]               keystrokes,
    output logic [15:0]               errors,
    output logic [TIME_W-1:0]         elapsed,
    output logic [TIME_W-1:0]         remaining,
    output logic                      finish
);
    localparam int         PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] GS_INGAME = 2'd2;
    localparam logic [4:0] KEY_BS    = 5'd27;
    localparam logic [4:0] KEY_SP    = 5'd28;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_TYPE, S_DONE} fsm_t;
    fsm_t fsm;

    logic [CHAR_W-1:0] chars_q [MAX_LEN];
    logic [CHAR_W-1:0] word_q  [MAX_LEN];
    logic [CUR_W-1:0]  len_q;
    logic [PRE_W-1:0]  pre_q;

    logic              tick, limit_hit, count_hit, time_sat, end_cond, is_letter;
    logic [CHAR_W-1:0] key_char;

    assign tick      = (pre_q == PRE_W'(TICK_DIV - 1));
    assign limit_hit = (remaining == '0);
    assign count_hit = (words_done >= target);
    assign time_sat  = &elapsed;
    assign is_letter = (key_code >= 5'd1) && (key_code <= 5'd26);
    assign key_char  = CHAR_W'(key_code);

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) typed[i*CHAR_W +: CHAR_W] = chars_q[i];
    end

    // Leading-equal prefix of the typed buffer against the latched word.
    always_comb begin
        logic run;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        match = '0;
        run   = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (run && (i < int'(cursor)) && (chars_q[i] == word_q[i])) match = match + 1'b1;
            else run = 1'b0;
        end
    end

    always_comb begin
        case (mode)
            2'd0:    end_cond = limit_hit;
            2'd1:    end_cond = count_hit;
            2'd2:    end_cond = limit_hit | count_hit;
            default: end_cond = 1'b0;
        endcase
        end_cond = end_cond | time_sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm        <= S_IDLE;
            word_req   <= 1'b0;
            cursor     <= '0;
            len_q      <= '0;
            pre_q      <= '0;
            words_done <= '0;
            keystrokes <= '0;
            errors     <= '0;
            elapsed    <= '0;
            remaining  <= '0;
            finish     <= 1'b0;
            // NOTE: the character arrays are small flop banks, so they reset with the rest of the state.
            for (int i = 0; i < MAX_LEN; i++) begin
                chars_q[i] <= '0;
                word_q[i]  <= '0;
            end
        end else if (state != GS_INGAME || fsm == S_IDLE) begin
            if (state == GS_INGAME) fsm <= S_FETCH;
            else                    fsm <= S_IDLE;
            word_req   <= (state == GS_INGAME);
            cursor     <= '0;
            len_q      <= '0;
            pre_q      <= '0;
            words_done <= '0;
            keystrokes <= '0;
            errors     <= '0;
            elapsed    <= '0;
            finish     <= 1'b0;
            remaining  <= TIME_W'(32'(target) * TPS);
            for (int i = 0; i < MAX_LEN; i++) begin
                chars_q[i] <= '0;
                word_q[i]  <= '0;
            end
        end else if (fsm != S_DONE) begin
            if (tick) begin
                pre_q <= '0;
                if (!time_sat)  elapsed   <= elapsed + 1'b1;
                if (!limit_hit) remaining <= remaining - 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end

            if (fsm == S_FETCH) begin
                if (word_ack && !end_cond) begin
                    for (int i = 0; i < MAX_LEN; i++) word_q[i] <= word[i*CHAR_W +: CHAR_W];
                    len_q    <= word_len;
                    word_req <= 1'b0;
                    fsm      <= S_TYPE;
                end
            end else if (key_stb) begin
                if (is_letter) begin
                    if (!(&keystrokes)) keystrokes <= keystrokes + 16'd1;
                    if (cursor < CUR_W'(MAX_LEN)) begin
                        chars_q[cursor] <= key_char;
                        cursor          <= cursor + 1'b1;
                        if ((cursor >= len_q || key_char != word_q[cursor]) && !(&errors))
                            errors <= errors + 16'd1;
                    end else if (!(&errors)) begin
                        errors <= errors + 16'd1;
                    end
                end else if (key_code == KEY_BS && cursor != '0) begin
                    chars_q[cursor - 1'b1] <= '0;
                    cursor                 <= cursor - 1'b1;
                    if (!(&keystrokes)) keystrokes <= keystrokes + 16'd1;
                end else if (key_code == KEY_SP && cursor != '0) begin
                    if (cursor == len_q && match == len_q) begin
                        if (!(&words_done)) words_done <= words_done + 1'b1;
                    end else if (!(&errors)) begin
                        errors <= errors + 16'd1;
                    end
                    for (int i = 0; i < MAX_LEN; i++) chars_q[i] <= '0;
                    cursor   <= '0;
                    word_req <= 1'b1;
                    fsm      <= S_FETCH;
                end
            end

            // NOTE: last non-blocking assignment wins, so the end transition overrides a pending fetch.
            if (end_cond) begin
                fsm      <= S_DONE;
                word_req <= 1'b0;
                finish   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_typing_tracker.sv
// tb_typing_tracker: directed race scenarios followed by randomized games, with every
// cycle compared against a queue-based behavioural model of the typing rules.
module tb_typing_tracker;
    localparam int MAX_LEN  = 25;
    localparam int CHAR_W   = 5;
    localparam int CNT_W    = 7;
    localparam int TIME_W   = 15;
    localparam int TICK_DIV = 4;
    localparam int TPS      = 2;
    localparam int CUR_W    = $clog2(MAX_LEN + 1);
    localparam int TMAX     = (1 << TIME_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [1:0]                state, mode;
    logic [CNT_W-1:0]          target;
    logic                      key_stb;
    logic [4:0]                key_code;
    logic [MAX_LEN*CHAR_W-1:0] word;
    logic [CUR_W-1:0]          word_len;
    logic                      word_req, word_ack;
    logic [MAX_LEN*CHAR_W-1:0] typed;
    logic [CUR_W-1:0]          cursor, match;
    logic [CNT_W-1:0]          words_done;
    logic [15:0]               keystrokes, errors;
    logic [TIME_W-1:0]         elapsed, remaining;
    logic                      finish;

    typing_tracker #(
        .MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .CNT_W(CNT_W), .TIME_W(TIME_W),
        .TICK_DIV(TICK_DIV), .TPS(TPS)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .mode(mode), .target(target),
        .key_stb(key_stb), .key_code(key_code), .word(word), .word_len(word_len),
        .word_req(word_req), .word_ack(word_ack), .typed(typed), .cursor(cursor),
        .match(match), .words_done(words_done), .keystrokes(keystrokes),
        .errors(errors), .elapsed(elapsed), .remaining(remaining), .finish(finish)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 waiting for word, 2 typing, 3 game over.
    int ph;
    int m_buf[$];
    int m_word[MAX_LEN];
    int m_len, m_words, m_keys, m_errs, m_active, m_base;
    bit m_req, m_fin;
    int total = 0;
    int bad   = 0;

    function automatic int m_ticks();
        return m_active / TICK_DIV;
    endfunction

    function automatic int m_elapsed();
        return (m_ticks() > TMAX) ? TMAX : m_ticks();
    endfunction

    function automatic int m_remaining();
        return (m_base > m_ticks()) ? m_base - m_ticks() : 0;
    endfunction

    function automatic int m_match();
        int n = 0;
        foreach (m_buf[i]) begin
            if (m_buf[i] != m_word[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [MAX_LEN*CHAR_W-1:0] m_typed();
        logic [MAX_LEN*CHAR_W-1:0] v = '0;
        foreach (m_buf[i]) v[i*CHAR_W +: CHAR_W] = CHAR_W'(m_buf[i]);
        return v;
    endfunction

    function automatic bit m_end();
        bit lim = (m_remaining() == 0);
        bit cnt = (m_words >= int'(target));
        bit e   = (mode == 2'd0 && lim) || (mode == 2'd1 && cnt) || (mode == 2'd2 && (lim || cnt));
        return e || (m_elapsed() == TMAX);
    endfunction

    task automatic m_clear();
        m_buf.delete();
        foreach (m_word[i]) m_word[i] = 0;
        m_len = 0; m_words = 0; m_keys = 0; m_errs = 0; m_active = 0;
        m_req = 1'b0; m_fin = 1'b0;
    endtask

    task automatic m_reset();
        m_clear();
        ph = 0;
        m_base = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit fin_now, go_fetch;
        int kc, pos;
        if (!rst) return;
        if (state != 2'd2 || ph == 0) begin
            m_clear();
            m_base = (int'(target) * TPS) & TMAX;
            ph     = (state == 2'd2) ? 1 : 0;
            m_req  = (state == 2'd2);
            return;
        end
        if (ph == 3) return;
        fin_now  = m_end();
        go_fetch = 1'b0;
        m_active++;
        if (ph == 1) begin
            if (word_ack && !fin_now) begin
                for (int i = 0; i < MAX_LEN; i++) m_word[i] = int'(word[i*CHAR_W +: CHAR_W]);
                m_len = int'(word_len);
                m_req = 1'b0;
                ph    = 2;
            end
        end else if (key_stb) begin
            kc  = int'(key_code);
            pos = m_buf.size();
            if (kc >= 1 && kc <= 26) begin
                if (m_keys < 65535) m_keys++;
                if (pos < MAX_LEN) begin
                    if ((pos >= m_len || kc != m_word[pos]) && m_errs < 65535) m_errs++;
                    m_buf.push_back(kc);
                end else if (m_errs < 65535) m_errs++;
            end else if (kc == 27 && pos > 0) begin
                void'(m_buf.pop_back());
                if (m_keys < 65535) m_keys++;
            end else if (kc == 28 && pos > 0) begin
                if (pos == m_len && m_match() == m_len) begin
                    if (m_words < 127) m_words++;
                end else if (m_errs < 65535) m_errs++;
                m_buf.delete();
                go_fetch = 1'b1;
            end
        end
        if (fin_now) begin
            ph = 3; m_fin = 1'b1; m_req = 1'b0;
        end else if (go_fetch) begin
            ph = 1; m_req = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("word_req",   128'(word_req),   128'(m_req));
        check("typed",      128'(typed),      128'(m_typed()));
        check("cursor",     128'(cursor),     128'(m_buf.size()));
        check("match",      128'(match),      128'(m_match()));
        check("words_done", 128'(words_done), 128'(m_words));
        check("keystrokes", 128'(keystrokes), 128'(m_keys));
        check("errors",     128'(errors),     128'(m_errs));
        check("elapsed",    128'(elapsed),    128'(m_elapsed()));
        check("remaining",  128'(remaining),  128'(m_remaining()));
        check("finish",     128'(finish),     128'(m_fin));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        key_stb  = 1'b0;
        word_ack = 1'b0;
    endtask

    task automatic press(input int code);
        key_stb  = 1'b1;
        key_code = 5'(code);
        step();
        check_all();
    endtask

    task automatic load_cat();
        word = '0;
        word[0*CHAR_W +: CHAR_W] = CHAR_W'(3);
        word[1*CHAR_W +: CHAR_W] = CHAR_W'(1);
        word[2*CHAR_W +: CHAR_W] = CHAR_W'(20);
        word_len = CUR_W'(3);
    endtask

    task automatic fetch_word();
        int n = 0;
        while (word_req !== 1'b1 && n < 20) begin
            step(); check_all(); n++;
        end
        check("req_seen", 128'(word_req), 128'(1));
        word_ack = 1'b1;
        step();
        check_all();
    endtask

    task automatic new_game(input logic [1:0] md, input logic [CNT_W-1:0] tg);
        state = 2'd0; step(); check_all();
        mode = md; target = tg; step(); check_all();
        check("idle_remaining", 128'(remaining), 128'((int'(tg) * TPS) & TMAX));
        state = 2'd2; step(); check_all();
        check("req_rise", 128'(word_req), 128'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, e0, el0, n, r, kc, wl;
        state = 2'd0; mode = 2'd0; target = '0; key_stb = 1'b0; key_code = '0;
        word = '0; word_len = '0; word_ack = 1'b0;
        rst = 1'b0;
        m_reset();
        #2;
        check_all();
        check("reset_remaining", 128'(remaining), 128'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Fetch and exact submit.
        new_game(2'd1, 7'd2);
        load_cat(); fetch_word();
        press(3); press(1); press(20);
        check("exact_match", 128'(match), 128'(3));
        press(28);
        check("exact_words", 128'(words_done), 128'(1));
        check("exact_errors", 128'(errors), 128'(0));
        check("exact_keys", 128'(keystrokes), 128'(3));
        check("exact_req", 128'(word_req), 128'(1));

        // Wrong letter fixed by backspace, then submit.
        new_game(2'd1, 7'd5);
        load_cat(); fetch_word();
        press(3); press(2); press(27); press(1); press(20); press(28);
        check("bs_words", 128'(words_done), 128'(1));
        check("bs_errors", 128'(errors), 128'(1));
        check("bs_keys", 128'(keystrokes), 128'(5));

        // Overflow: 26 letters into a 25-character buffer.
        new_game(2'd1, 7'd5);
        load_cat(); fetch_word();
        for (int i = 0; i < 26; i++) press(1);
        check("ovf_cursor", 128'(cursor), 128'(25));
        check("ovf_errors", 128'(errors), 128'(25));
        check("ovf_keys", 128'(keystrokes), 128'(26));

        // Failed submit.
        new_game(2'd1, 7'd5);
        load_cat(); fetch_word();
        press(3); press(1); press(28);
        check("fail_words", 128'(words_done), 128'(0));
        check("fail_errors", 128'(errors), 128'(1));
        check("fail_cursor", 128'(cursor), 128'(0));
        check("fail_typed", 128'(typed), 128'(0));
        check("fail_req", 128'(word_req), 128'(1));

        // Time limit, with a key on the finishing edge.
        new_game(2'd0, 7'd3);
        check("time_start", 128'(remaining), 128'(6));
        load_cat(); fetch_word();
        n = 0;
        while (m_remaining() != 0 && n < 100) begin
            step(); check_all(); n++;
        end
        check("time_zero", 128'(remaining), 128'(0));
        check("time_not_yet", 128'(finish), 128'(0));
        k0 = m_keys;
        press(3);
        check("time_finish", 128'(finish), 128'(1));
        check("time_key_on_finish", 128'(keystrokes), 128'(k0 + 1));
        k0 = m_keys; e0 = m_errs; el0 = m_elapsed();
        press(1); press(27); press(28);
        for (int i = 0; i < 8; i++) begin step(); check_all(); end
        check("done_keys", 128'(keystrokes), 128'(k0));
        check("done_errors", 128'(errors), 128'(e0));
        check("done_elapsed", 128'(elapsed), 128'(el0));

        // Word target of zero ends on the first fetch cycle.
        new_game(2'd1, 7'd0);
        step(); check_all();
        check("zero_target_finish", 128'(finish), 128'(1));
        check("zero_target_req", 128'(word_req), 128'(0));

        // Mixed mode ends on the word target; an ack on that edge is not consumed.
        new_game(2'd2, 7'd1);
        load_cat(); fetch_word();
        press(3); press(1); press(20); press(28);
        check("mixed_words", 128'(words_done), 128'(1));
        check("mixed_not_yet", 128'(finish), 128'(0));
        word_ack = 1'b1;
        step(); check_all();
        check("mixed_finish", 128'(finish), 128'(1));
        check("mixed_req", 128'(word_req), 128'(0));
        check("mixed_time_left", 128'(remaining), 128'(1));
        state = 2'd0; step(); check_all();
        check("abort_finish", 128'(finish), 128'(0));
        check("abort_words", 128'(words_done), 128'(0));
        check("abort_keys", 128'(keystrokes), 128'(0));
        check("abort_remaining", 128'(remaining), 128'(2));

        // Asynchronous reset in the middle of typing.
        state = 2'd2; step(); check_all();
        fetch_word();
        press(3);
        rst = 1'b0;
        m_reset();
        #2;
        check_all();
        check("rst_cursor", 128'(cursor), 128'(0));
        check("rst_typed", 128'(typed), 128'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Randomized games in every mode.
        for (int round = 0; round < 12; round++) begin
            state = 2'd0; step(); check_all();
            mode   = 2'($urandom_range(0, 3));
            target = CNT_W'($urandom_range(0, 6));
            step(); check_all();
            for (int cyc = 0; cyc < 200; cyc++) begin
                state   = ($urandom_range(0, 99) == 0) ? 2'd0 : 2'd2;
                key_stb = ($urandom_range(0, 99) < 50);
                r = $urandom_range(0, 99);
                n = m_buf.size();
                if (r < 45)      kc = (n < m_len) ? m_word[n] : int'($urandom_range(1, 26));
                else if (r < 60) kc = $urandom_range(1, 26);
                else if (r < 75) kc = 27;
                else if (r < 92) kc = 28;
                else begin
                    kc = $urandom_range(29, 32);
                    if (kc == 32) kc = 0;
                end
                key_code = 5'(kc);
                if (m_req && $urandom_range(0, 3) == 0) begin
                    word = '0;
                    wl   = $urandom_range(1, 6);
                    for (int i = 0; i < wl; i++) word[i*CHAR_W +: CHAR_W] = CHAR_W'($urandom_range(1, 26));
                    word_len = CUR_W'(wl);
                    word_ack = 1'b1;
                end else if ($urandom_range(0, 49) == 0) begin
                    word_ack = 1'b1;
                end
                step();
                check_all();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
